// File: rtl/down_convert_pkg.sv
// Shared constants and helpers for the down_convert_corr correlator.
//   - default width localparams for the correlator parameters
//   - code tap index constants (Early / Prompt / Late)
//   - sat_add: signed add clamped to a caller-chosen width
package down_convert_pkg;

    localparam int IF_W_DEF  = 2;
    localparam int NCO_W_DEF = 16;
    localparam int ACC_W_DEF = 32;
    localparam int N_TAP_DEF = 3;
    localparam int CNT_W_DEF = 16;

    localparam int TAP_E = 0;
    localparam int TAP_P = 1;
    localparam int TAP_L = 2;

    // Adds in 64 bits and clamps to the signed range of a w-bit word.
    // The operands must already fit in w bits (w <= 62), so the 64-bit
    // add itself never overflows.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        if (sum > hi)      sat_add = hi;
        else if (sum < lo) sat_add = lo;
        else               sat_add = sum;
    endfunction

endpackage

// File: rtl/down_convert_corr_accum.sv
// corr_accum: one I/Q integrate-and-dump accumulator pair for one code tap.
// Macro DOWN_CONVERT_SAT_EN selects saturating updates; otherwise wrap.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   valid_i             mixed sample present this cycle
//   dump_i              last sample of epoch (qualified by valid_i)
//   chip_i              code chip for this tap: 1 -> +1, 0 -> -1
//   mi_i, mq_i          carrier-mixed I/Q products
//   sum_i_o, sum_q_o    accumulator value including the current term
module corr_accum
    import down_convert_pkg::*;
#(
    parameter int M_W   = 18,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_i,
    input  logic                    dump_i,
    input  logic                    chip_i,
    input  logic signed [M_W-1:0]   mi_i,
    input  logic signed [M_W-1:0]   mq_i,
    output logic signed [ACC_W-1:0] sum_i_o,
    output logic signed [ACC_W-1:0] sum_q_o
);

    logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
    logic signed [63:0]      mi_ext, mq_ext;

    assign mi_ext = 64'(mi_i);
    assign mq_ext = 64'(mq_i);

`ifdef DOWN_CONVERT_SAT_EN
    logic signed [63:0] term_i, term_q;
    assign term_i  = chip_i ? mi_ext : -mi_ext;
    assign term_q  = chip_i ? mq_ext : -mq_ext;
    assign sum_i_o = ACC_W'(sat_add(64'(acc_i_q), term_i, ACC_W));
    assign sum_q_o = ACC_W'(sat_add(64'(acc_q_q), term_q, ACC_W));
`else
    // Negate after sign-extension so the most negative product negates cleanly.
    logic signed [ACC_W-1:0] term_i, term_q;
    assign term_i  = chip_i ? ACC_W'(mi_ext) : -(ACC_W'(mi_ext));
    assign term_q  = chip_i ? ACC_W'(mq_ext) : -(ACC_W'(mq_ext));
    assign sum_i_o = acc_i_q + term_i;
    assign sum_q_o = acc_q_q + term_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else if (valid_i) begin
            // The dump sample is handed out via sum_*_o; integration restarts at 0.
            acc_i_q <= dump_i ? '0 : sum_i_o;
            acc_q_q <= dump_i ? '0 : sum_q_o;
        end
    end

endmodule

// File: rtl/down_convert_corr.sv
// down_convert_corr: multi-tap carrier/code wipe-off integrate-and-dump
// correlator. Stage 1 mixes IF with the carrier NCO; stage 2 applies each
// tap's code sign and integrates. Dumps latch into a held output register
// with a valid/ready handshake.
// Macro DOWN_CONVERT_SAT_EN: saturating accumulators (default: wrap).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid, if_in            sample qualifier and signed IF sample
//   cos_phase, sin_phase       signed carrier NCO outputs
//   code_taps                  per-tap code chip (1 -> +1, 0 -> -1)
//   dump                       last sample of epoch, only with in_valid
//   out_valid, out_ready       output handshake
//   i_acc, q_acc               latched integrals, tap k at [k*ACC_W +: ACC_W]
//   epoch_cnt                  samples integrated in the latched epoch
//   overrun                    pulse: unread output was overwritten
module down_convert_corr
    import down_convert_pkg::*;
#(
    parameter int IF_W  = IF_W_DEF,
    parameter int NCO_W = NCO_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int N_TAP = N_TAP_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [IF_W-1:0]   if_in,
    input  logic signed [NCO_W-1:0]  cos_phase,
    input  logic signed [NCO_W-1:0]  sin_phase,
    input  logic [N_TAP-1:0]         code_taps,
    input  logic                     dump,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_TAP*ACC_W-1:0]   i_acc,
    output logic [N_TAP*ACC_W-1:0]   q_acc,
    output logic [CNT_W-1:0]         epoch_cnt,
    output logic                     overrun
);

    localparam int M_W = IF_W + NCO_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage 1: mixer products with their qualifiers.
    logic signed [M_W-1:0] mi_q, mq_q;
    logic [N_TAP-1:0]      taps_q;
    logic                  valid_q, dump_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mi_q    <= '0;
            mq_q    <= '0;
            taps_q  <= '0;
            valid_q <= 1'b0;
            dump_q  <= 1'b0;
        end else begin
            mi_q    <= M_W'(if_in) * M_W'(cos_phase);
            mq_q    <= M_W'(if_in) * M_W'(sin_phase);
            taps_q  <= code_taps;
            valid_q <= in_valid;
            dump_q  <= dump;
        end
    end

    // Stage 2: per-tap integrators.
    logic signed [ACC_W-1:0] sum_i [N_TAP];
    logic signed [ACC_W-1:0] sum_q [N_TAP];

    for (genvar k = 0; k < N_TAP; k++) begin : g_tap
        corr_accum #(.M_W(M_W), .ACC_W(ACC_W)) u_accum (
            .clk     (clk),
            .reset   (reset),
            .valid_i (valid_q),
            .dump_i  (dump_q),
            .chip_i  (taps_q[k]),
            .mi_i    (mi_q),
            .mq_i    (mq_q),
            .sum_i_o (sum_i[k]),
            .sum_q_o (sum_q[k])
        );
    end

    // Sample counter, epoch latch and handshake.
    logic                   dump_fire;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;
    logic [N_TAP*ACC_W-1:0] i_out_q, q_out_q;
    logic [CNT_W-1:0]       epoch_q;

    assign dump_fire = valid_q & dump_q;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (dump_fire) begin
            cnt_d       = '0;
            out_valid_d = 1'b1;
            // A handshake in the same cycle frees the register: no overrun.
            overrun_d   = out_valid_q & ~out_ready;
        end else begin
            if (valid_q) cnt_d = cnt_inc;
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            epoch_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            if (dump_fire) begin
                for (int k = 0; k < N_TAP; k++) begin
                    i_out_q[k*ACC_W +: ACC_W] <= sum_i[k];
                    q_out_q[k*ACC_W +: ACC_W] <= sum_q[k];
                end
                epoch_q <= cnt_inc;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign i_acc     = i_out_q;
    assign q_acc     = q_out_q;
    assign epoch_cnt = epoch_q;

endmodule

// File: tb/tb_down_convert_corr.sv
module tb_down_convert_corr;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, dump, out_ready;
    logic signed [1:0] if_in;
    logic signed [15:0] cos_phase, sin_phase;
    logic [2:0]        code_taps;

    logic        out_valid, overrun;
    logic [95:0] i_acc, q_acc;
    logic [15:0] epoch_cnt;

    logic        s_out_valid, s_overrun;
    logic [23:0] s_i_acc, s_q_acc;
    logic [15:0] s_epoch_cnt;

    always #5 clk = ~clk;

    down_convert_corr dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .if_in(if_in),
        .cos_phase(cos_phase), .sin_phase(sin_phase), .code_taps(code_taps),
        .dump(dump), .out_valid(out_valid), .out_ready(out_ready),
        .i_acc(i_acc), .q_acc(q_acc), .epoch_cnt(epoch_cnt), .overrun(overrun)
    );

    // Narrow-accumulator instance for the overflow behaviour.
    down_convert_corr #(.ACC_W(8)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .if_in(if_in),
        .cos_phase(cos_phase), .sin_phase(sin_phase), .code_taps(code_taps),
        .dump(dump), .out_valid(s_out_valid), .out_ready(out_ready),
        .i_acc(s_i_acc), .q_acc(s_q_acc), .epoch_cnt(s_epoch_cnt), .overrun(s_overrun)
    );

    typedef struct {
        int ei[3];
        int eq[3];
        int cnt;
    } exp_t;

    typedef struct {
        int         ifv;
        int         c;
        int         s;
        logic [2:0] taps;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   overrun_seen = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(int i0, int i1, int i2, int q0, int q1, int q2, int cnt);
        exp_t e;
        e.ei[0] = i0; e.ei[1] = i1; e.ei[2] = i2;
        e.eq[0] = q0; e.eq[1] = q1; e.eq[2] = q2;
        e.cnt   = cnt;
        return e;
    endfunction

    function automatic vec_t mk_vec(int ifv, int c, int s, logic [2:0] taps, exp_t e);
        vec_t v;
        v.ifv = ifv; v.c = c; v.s = s; v.taps = taps; v.e = e;
        return v;
    endfunction

    task automatic drive(input logic v, input int ifv, input int c, input int s,
                         input logic [2:0] t, input logic d);
        @(posedge clk);
        #1;
        in_valid  = v;
        if_in     = 2'(ifv);
        cos_phase = 16'(c);
        sin_phase = 16'(s);
        code_taps = t;
        dump      = d;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 3'b000, 1'b0);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1;
        out_ready = r;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Scoreboard: an overwritten epoch is discarded; a handshake consumes the front.
    always @(negedge clk) begin
        if (!reset) begin
            if (overrun) begin
                overrun_seen++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        check($sformatf("i_acc[%0d]", k), longint'($signed(i_acc[k*32 +: 32])), e.ei[k]);
                        check($sformatf("q_acc[%0d]", k), longint'($signed(q_acc[k*32 +: 32])), e.eq[k]);
                    end
                    check("epoch_cnt", epoch_cnt, e.cnt);
                end
            end
        end
    end

    vec_t tbl[4];
    int   sat_i, sat_q, sat_i2;

    initial begin
        // Single-sample epochs, dumped back to back (dump coincides with handshake).
        tbl[0] = mk_vec( 1,      3,     4, 3'b111, mk_exp(3, 3, 3, 4, 4, 4, 1));
        tbl[1] = mk_vec(-1,      5,    -6, 3'b101, mk_exp(-5, 5, -5, 6, -6, 6, 1));
        tbl[2] = mk_vec(-2, -32768, 32767, 3'b000,
                        mk_exp(-65536, -65536, -65536, 65534, 65534, 65534, 1));
        tbl[3] = mk_vec( 1, -32768,     0, 3'b010, mk_exp(32768, -32768, 32768, 0, 0, 0, 1));

`ifdef DOWN_CONVERT_SAT_EN
        sat_i = 127; sat_q = -128; sat_i2 = 27;
`else
        sat_i = 44;  sat_q = -44;  sat_i2 = -56;
`endif

        reset = 1'b1; in_valid = 1'b0; dump = 1'b0; out_ready = 1'b1;
        if_in = '0; cos_phase = '0; sin_phase = '0; code_taps = '0;
        wait_neg(2);
        check("reset out_valid", out_valid, 0);
        check("reset overrun", overrun, 0);
        check("reset i_acc", i_acc, 0);
        check("reset q_acc", q_acc, 0);
        check("reset epoch_cnt", epoch_cnt, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Constant input, latency check.
        sb.push_back(mk_exp(1000, 1000, 1000, -500, -500, -500, 10));
        for (int i = 0; i < 10; i++) drive(1'b1, 1, 100, -50, 3'b111, i == 9);
        idle();
        @(negedge clk);
        check("latency out_valid t+1", out_valid, 0);
        @(negedge clk);
        check("latency out_valid t+2", out_valid, 1);
        wait_neg(2);

        // Code signs.
        sb.push_back(mk_exp(56, -56, 56, 24, -24, 24, 4));
        for (int i = 0; i < 4; i++) drive(1'b1, -2, 7, 3, 3'b010, i == 3);
        idle();
        wait_neg(4);

        // Table vectors.
        for (int v = 0; v < 4; v++) begin
            sb.push_back(tbl[v].e);
            drive(1'b1, tbl[v].ifv, tbl[v].c, tbl[v].s, tbl[v].taps, 1'b1);
        end
        idle();
        wait_neg(4);

        // Back-pressure with overwrite.
        set_ready(1'b0);
        sb.push_back(mk_exp(30, 30, 30, 0, 0, 0, 3));
        for (int i = 0; i < 3; i++) drive(1'b1, 1, 10, 0, 3'b111, i == 2);
        sb.push_back(mk_exp(10, 10, 10, 5, 5, 5, 5));
        for (int i = 0; i < 5; i++) drive(1'b1, 1, 2, 1, 3'b111, i == 4);
        idle();
        @(negedge clk);
        check("bp held i_acc[0]", longint'($signed(i_acc[31:0])), 30);
        check("bp held overrun", overrun, 0);
        @(negedge clk);
        check("bp overrun pulse", overrun, 1);
        check("bp new i_acc[0]", longint'($signed(i_acc[31:0])), 10);
        check("bp new epoch_cnt", epoch_cnt, 5);
        @(negedge clk);
        check("bp overrun one cycle", overrun, 0);
        check("bp still valid", out_valid, 1);
        set_ready(1'b1);
        wait_neg(2);
        check("bp cleared", out_valid, 0);

        // Gaps and a dump on an invalid cycle.
        for (int i = 0; i < 8; i++) drive((i % 2) == 0, 1, 1, -1, 3'b111, i == 3);
        idle();
        wait_neg(3);
        check("gap no output", out_valid, 0);
        sb.push_back(mk_exp(5, 5, 5, -5, -5, -5, 5));
        drive(1'b1, 1, 1, -1, 3'b111, 1'b1);
        idle();
        wait_neg(3);

        // Narrow accumulator overflow.
        sb.push_back(mk_exp(300, 300, 300, -300, -300, -300, 3));
        for (int i = 0; i < 3; i++) drive(1'b1, 1, 100, -100, 3'b111, i == 2);
        idle();
        wait_neg(2);
        check("small out_valid", s_out_valid, 1);
        check("small i_acc[0]", longint'($signed(s_i_acc[7:0])), sat_i);
        check("small q_acc[2]", longint'($signed(s_q_acc[23:16])), sat_q);
        wait_neg(2);
        sb.push_back(mk_exp(200, 200, 200, 0, 0, 0, 4));
        for (int i = 0; i < 4; i++) drive(1'b1, 1, (i == 3) ? -100 : 100, 0, 3'b111, i == 3);
        idle();
        wait_neg(2);
        check("small i_acc[1] after clip", longint'($signed(s_i_acc[15:8])), sat_i2);
        wait_neg(2);

        // Reset mid-epoch.
        for (int i = 0; i < 6; i++) drive(1'b1, 1, 9, -3, 3'b111, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid reset i_acc", i_acc, 0);
        check("mid reset q_acc", q_acc, 0);
        check("mid reset epoch_cnt", epoch_cnt, 0);
        check("mid reset out_valid", out_valid, 0);
        @(posedge clk); #1 reset = 1'b0;
        sb.push_back(mk_exp(18, 18, 18, -6, -6, -6, 2));
        for (int i = 0; i < 2; i++) drive(1'b1, 1, 9, -3, 3'b111, i == 1);
        idle();
        wait_neg(4);

        check("scoreboard drained", sb.size(), 0);
        check("overrun count", overrun_seen, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_convert_corr.md
# down_convert_corr

Parametrised multi-tap carrier/code wipe-off and integrate-and-dump correlator for the GNSS baseband chain. Each valid IF sample is mixed with the local carrier NCO (cos/sin), multiplied by ±1 for each code tap (e.g. Early/Prompt/Late), and accumulated per tap into I/Q integrators. On an epoch dump the integrals are latched into a held output register with a valid/ready handshake, and the integrators restart. It sits between the IF sampler/carrier NCO and the tracking-loop discriminators.

## Interface
- IF_W, 2: IF sample width, signed two's complement
- NCO_W, 16: carrier cos/sin width, signed
- ACC_W, 32: accumulator and output width per I/Q value
- N_TAP, 3: number of code taps (tap 0 = Early, 1 = Prompt, 2 = Late for N_TAP=3)
- CNT_W, 16: epoch sample-counter width

Ports (clock and reset: clk; reset, asynchronous, active-high):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  sample qualifier
- if_in  in  IF_W  signed IF sample
- cos_phase  in  NCO_W  signed local carrier cosine
- sin_phase  in  NCO_W  signed local carrier sine
- code_taps  in  N_TAP  code chip per tap; 1 → +1, 0 → −1
- dump  in  1  last sample of epoch; only honoured when in_valid=1
- out_valid  out  1  latched integrals available
- out_ready  in  1  consumer accepts output
- i_acc  out  N_TAP*ACC_W  tap k at [k*ACC_W +: ACC_W], signed
- q_acc  out  N_TAP*ACC_W  same packing
- epoch_cnt  out  CNT_W  samples integrated in latched epoch
- overrun  out  1  one-cycle pulse: unread output overwritten

## Operation
- Stage 1 (registered): mi = if_in*cos_phase, mq = if_in*sin_phase, full width IF_W+NCO_W signed; code_taps, dump, and in_valid delayed alongside.
- Stage 2: per tap k, term = code_taps[k] ? +m : −m, sign-extended to ACC_W; acc_k += term only when the delayed valid is 1.
- Sample counter increments per valid sample and saturates at 2^CNT_W−1.
- Dump (delayed, valid): output registers ← acc + term (this sample included); epoch_cnt ← counter+1; accumulators and counter ← 0; out_valid ← 1.
- Handshake: out_valid && out_ready clears out_valid next cycle. Outputs remain stable while out_valid && !out_ready.
- Dump while out_valid && !out_ready: new values overwrite the output registers, out_valid stays 1, and overrun pulses for 1 cycle.
- Dump in the same cycle as a handshake: the new values load and out_valid stays 1. No overrun.
- dump with in_valid=0: ignored.
- Reset: all accumulators, counter, pipeline valids, i_acc, q_acc, epoch_cnt, out_valid, and overrun → 0. Reset mid-epoch discards the partial integral.

## Timing
- Sample accepted at cycle t with dump → out_valid, i_acc, and q_acc visible at t+2 (latency 2).
- Full throughput: 1 sample per cycle, no input back-pressure.
- in_valid gaps do not disturb the accumulation.
- overrun is asserted in the same cycle out_valid/data update.

## Configuration
- DOWN_CONVERT_SAT_EN defined: accumulator updates saturate to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Once an accumulator has clipped, it keeps accumulating from the clipped value.
- DOWN_CONVERT_SAT_EN undefined: accumulator updates use two's-complement wrap.

## Structure
- Package down_convert_pkg:
  - tap index constants (TAP_E, TAP_P, TAP_L)
  - saturating-add function, parameterised by width
  - default width localparams
- Sub-module corr_accum: one I/Q accumulator pair with code sign, valid, clear-on-dump, and optional saturation. Instantiated N_TAP times via generate.

## Test plan
- Constant input: if_in=1, cos=100, sin=−50, all taps=1, 10 valid samples, dump on the 10th. Expect i_acc=1000 and q_acc=−500 for every tap, epoch_cnt=10, out_valid at t+2.
- Code signs: taps=3'b010 over 4 samples, if_in=−2, cos=7. Expect tap1 I=−56 and taps 0/2 I=+56.
- Back-pressure: out_ready=0, two dumps 5 samples apart. Expect the second epoch's values, overrun pulse on the second, then a handshake clears out_valid.
- Gaps and dump without valid: in_valid toggled 1/0 over 8 cycles (4 valid), and dump asserted on an invalid cycle. Expect no output. Then dump on a valid sample: epoch_cnt=5.
- Saturation: ACC_W=8, if_in=1, cos=100, 3 samples. Expect I=127 with DOWN_CONVERT_SAT_EN defined, and I=44 (300 mod 256) without it.
- Reset after 6 accumulated samples, then 2 samples and a dump. Expect epoch_cnt=2 with only those 2 samples integrated, and all outputs 0 during reset.
